// File: rtl/gpi_scan_pkg.sv
// Shared types and constants for the GPI scan controller: FSM state encoding,
// GPI register addresses and the two-sample debounce helper.
package gpi_scan_pkg;

  localparam int GPI_W = 8;

  localparam logic [2:0] GPI_CR_ADDR  = 3'h0;
  localparam logic [2:0] GPI_IDR_ADDR = 3'h4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CR_SETUP,
    S_CR_ACCESS,
    S_RD_SETUP,
    S_RD_ACCESS,
    S_UPDATE
  } gpi_state_t;

  // A bit follows the sample only when two consecutive samples agree.
  function automatic logic [GPI_W-1:0] gpi_debounce(
    input logic [GPI_W-1:0] sample,
    input logic [GPI_W-1:0] prev_sample,
    input logic [GPI_W-1:0] snapshot
  );
    logic [GPI_W-1:0] agree;
    agree = ~(sample ^ prev_sample);
    return (sample & agree) | (snapshot & ~agree);
  endfunction

endpackage

// File: rtl/gpi_edge_flags.sv
// Sticky rise/fall flags for the GPI scan controller plus the registered
// level interrupt derived from them.
module gpi_edge_flags
  import gpi_scan_pkg::*;
(
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             i_upd,
  input  logic [GPI_W-1:0] i_snapshot_old,
  input  logic [GPI_W-1:0] i_acc_new,
  input  logic [GPI_W-1:0] i_flag_clr,
  input  logic [GPI_W-1:0] i_irq_en,
  output logic [GPI_W-1:0] o_rise_flag,
  output logic [GPI_W-1:0] o_fall_flag,
  output logic             o_irq
);

  logic [GPI_W-1:0] r_rise;
  logic [GPI_W-1:0] r_fall;
  logic             r_irq;
  logic [GPI_W-1:0] w_rise_set;
  logic [GPI_W-1:0] w_fall_set;

  assign w_rise_set = i_upd ? (i_acc_new & ~i_snapshot_old) : '0;
  assign w_fall_set = i_upd ? (~i_acc_new & i_snapshot_old) : '0;

  // Clear is applied first so a simultaneous set survives.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_rise <= '0;
      r_fall <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_rise <= (r_rise & ~i_flag_clr) | w_rise_set;
      r_fall <= (r_fall & ~i_flag_clr) | w_fall_set;
      r_irq  <= |((r_rise | r_fall) & i_irq_en);
    end
  end

  assign o_rise_flag = r_rise;
  assign o_fall_flag = r_fall;
  assign o_irq       = r_irq;

endmodule

// File: rtl/gpi_scan_ctrl.sv
// Autonomous APB master that programs the GPI enable register, polls its
// input data register and keeps a snapshot; define GPI_SCAN_DEBOUNCE_EN for two-sample debounce.
module gpi_scan_ctrl
  import gpi_scan_pkg::*;
#(
  parameter int PERIOD_W = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                scan_en,
  input  logic [PERIOD_W-1:0] period,
  input  logic [GPI_W-1:0]    in_mask,
  input  logic [GPI_W-1:0]    irq_en,
  input  logic [GPI_W-1:0]    flag_clr,
  output logic                M_PSEL,
  output logic                M_PENABLE,
  output logic                M_PWRITE,
  output logic [2:0]          M_PADDR,
  output logic [31:0]         M_PWDATA,
  input  logic [31:0]         M_PRDATA,
  input  logic                M_PREADY,
  output logic [GPI_W-1:0]    snapshot,
  output logic [GPI_W-1:0]    rise_flag,
  output logic [GPI_W-1:0]    fall_flag,
  output logic                irq,
  output logic                busy
);

  gpi_state_t          r_state;
  logic [PERIOD_W-1:0] r_cnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [2:0]          r_paddr;
  logic [GPI_W-1:0]    r_pwdata;
  logic [GPI_W-1:0]    r_rdata;
  logic                r_busy;
  logic                r_cr_dirty;
  logic [GPI_W-1:0]    r_cr_mask;
  logic [GPI_W-1:0]    r_snapshot;

  logic [PERIOD_W-1:0] w_period_m1;
  logic                w_cr_dirty;
  logic                w_cr_done;
  logic                w_upd;
  logic [GPI_W-1:0]    w_sample;
  logic [GPI_W-1:0]    w_acc_new;
  logic                w_unused_prdata;

  assign w_period_m1     = (period == '0) ? '0 : period - 1'b1;
  assign w_cr_done       = (r_state == S_CR_ACCESS) && M_PREADY;
  assign w_cr_dirty      = r_cr_dirty || (in_mask != r_cr_mask);
  assign w_upd           = (r_state == S_UPDATE);
  assign w_unused_prdata = ^M_PRDATA[31:GPI_W];

  // Scan sequencer; APB outputs are loaded together with the next state.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan_en) begin
            r_state  <= S_CR_SETUP;
            r_busy   <= 1'b1;
            r_psel   <= 1'b1;
            r_pwrite <= 1'b1;
            r_paddr  <= GPI_CR_ADDR;
            r_pwdata <= in_mask;
          end
        end
        S_WAIT: begin
          if (!scan_en) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == w_period_m1) begin
            r_cnt  <= '0;
            r_psel <= 1'b1;
            if (w_cr_dirty) begin
              r_state  <= S_CR_SETUP;
              r_pwrite <= 1'b1;
              r_paddr  <= GPI_CR_ADDR;
              r_pwdata <= in_mask;
            end else begin
              r_state  <= S_RD_SETUP;
              r_pwrite <= 1'b0;
              r_paddr  <= GPI_IDR_ADDR;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CR_SETUP: begin
          r_state   <= S_CR_ACCESS;
          r_penable <= 1'b1;
        end
        S_CR_ACCESS: begin
          if (M_PREADY) begin
            r_penable <= 1'b0;
            if (scan_en) begin
              r_state  <= S_RD_SETUP;
              r_pwrite <= 1'b0;
              r_paddr  <= GPI_IDR_ADDR;
            end else begin
              r_state <= S_IDLE;
              r_psel  <= 1'b0;
              r_busy  <= 1'b0;
            end
          end
        end
        S_RD_SETUP: begin
          r_state   <= S_RD_ACCESS;
          r_penable <= 1'b1;
        end
        S_RD_ACCESS: begin
          if (M_PREADY) begin
            r_state   <= S_UPDATE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_rdata   <= M_PRDATA[GPI_W-1:0];
          end
        end
        S_UPDATE: begin
          if (scan_en) begin
            r_state <= S_WAIT;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // The mask applied to samples is the one the peripheral actually holds.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cr_dirty <= 1'b1;
      r_cr_mask  <= '0;
    end else if (w_cr_done) begin
      r_cr_mask  <= r_pwdata;
      r_cr_dirty <= (in_mask != r_pwdata);
    end else if (in_mask != r_cr_mask) begin
      r_cr_dirty <= 1'b1;
    end
  end

  assign w_sample = r_rdata & r_cr_mask;

`ifdef GPI_SCAN_DEBOUNCE_EN
  logic [GPI_W-1:0] r_prev_sample;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_prev_sample <= '0;
    end else if (w_upd) begin
      r_prev_sample <= w_sample;
    end
  end

  assign w_acc_new = gpi_debounce(w_sample, r_prev_sample, r_snapshot);
`else
  assign w_acc_new = w_sample;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_snapshot <= '0;
    end else if (w_upd) begin
      r_snapshot <= w_acc_new;
    end
  end

  gpi_edge_flags u_flags (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .i_upd         (w_upd),
    .i_snapshot_old(r_snapshot),
    .i_acc_new     (w_acc_new),
    .i_flag_clr    (flag_clr),
    .i_irq_en      (irq_en),
    .o_rise_flag   (rise_flag),
    .o_fall_flag   (fall_flag),
    .o_irq         (irq)
  );

  assign M_PSEL    = r_psel;
  assign M_PENABLE = r_penable;
  assign M_PWRITE  = r_pwrite;
  assign M_PADDR   = r_paddr;
  assign M_PWDATA  = {{(32-GPI_W){1'b0}}, r_pwdata};
  assign snapshot  = r_snapshot;
  assign busy      = r_busy;

endmodule

// File: tb/tb_gpi_scan_ctrl.sv
// Self-checking bench for gpi_scan_ctrl against a GPI slave model with
// registered PREADY, programmable stall and undefined unselected IDR bits.
module tb_gpi_scan_ctrl;

`ifdef GPI_SCAN_DEBOUNCE_EN
  localparam int ACC_SCANS = 2;
`else
  localparam int ACC_SCANS = 1;
`endif

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } xfer_t;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        scan_en = 1'b0;
  logic [15:0] period = 16'd4;
  logic [7:0]  in_mask = 8'h00;
  logic [7:0]  irq_en = 8'h00;
  logic [7:0]  flag_clr = 8'h00;
  logic        M_PSEL, M_PENABLE, M_PWRITE;
  logic [2:0]  M_PADDR;
  logic [31:0] M_PWDATA, M_PRDATA;
  logic        M_PREADY;
  logic [7:0]  snapshot, rise_flag, fall_flag;
  logic        irq, busy;

  logic [7:0]  idr = 8'h00;
  logic [7:0]  slv_cr;
  int          stall = 0;
  int          wcnt;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  xfer_t       exp_q[$];

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  gpi_scan_ctrl #(.PERIOD_W(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .scan_en(scan_en), .period(period),
    .in_mask(in_mask), .irq_en(irq_en), .flag_clr(flag_clr),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PWRITE(M_PWRITE),
    .M_PADDR(M_PADDR), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA),
    .M_PREADY(M_PREADY), .snapshot(snapshot), .rise_flag(rise_flag),
    .fall_flag(fall_flag), .irq(irq), .busy(busy)
  );

  // Unselected IDR bits read as 1 and upper bits carry junk.
  assign M_PRDATA = {24'hA5C35A, (idr & slv_cr) | ~slv_cr};

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      M_PREADY <= 1'b0;
      wcnt     <= 0;
      slv_cr   <= 8'h00;
    end else begin
      M_PREADY <= M_PSEL && M_PENABLE && (wcnt >= stall);
      wcnt     <= (M_PSEL && M_PENABLE) ? wcnt + 1 : 0;
      if (M_PSEL && M_PENABLE && M_PREADY && M_PWRITE && M_PADDR == 3'h0)
        slv_cr <= M_PWDATA[7:0];
    end
  end

  task automatic next_xfer(output xfer_t x, output int c, output bit ok);
    ok = 1'b0;
    c = 0;
    x = '{1'b0, 3'h0, 32'h0};
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge PCLK);
      if (M_PSEL && M_PENABLE && M_PREADY) begin
        ok = 1'b1;
        x = '{M_PWRITE, M_PADDR, M_PWDATA};
        c = cyc;
      end
    end
  endtask

  task automatic wait_read();
    xfer_t x;
    int c;
    bit ok;
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      next_xfer(x, c, ok);
      if (ok && !x.wr) got = 1'b1;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL read_timeout: read completed=%b required=1", got);
    end
  endtask

  task automatic settle();
    @(posedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge PCLK);
    n_vec++;
    if ({M_PSEL, M_PENABLE, M_PWRITE, M_PADDR} !== 6'b0) begin
      n_err++; $display("FAIL reset_apb_ctl: got %b required 0", {M_PSEL, M_PENABLE, M_PWRITE, M_PADDR});
    end
    n_vec++;
    if (M_PWDATA !== 32'h0) begin
      n_err++; $display("FAIL reset_pwdata: got %h required 0", M_PWDATA);
    end
    n_vec++;
    if ({snapshot, rise_flag, fall_flag} !== 24'h0) begin
      n_err++; $display("FAIL reset_data: got %h required 0", {snapshot, rise_flag, fall_flag});
    end
    n_vec++;
    if ({irq, busy} !== 2'b00) begin
      n_err++; $display("FAIL reset_irq_busy: got %b required 00", {irq, busy});
    end
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    n_vec++;
    if ({busy, M_PSEL} !== 2'b00) begin
      n_err++; $display("FAIL idle_no_scan: busy/psel got %b required 00", {busy, M_PSEL});
    end
  endtask

  task automatic test_first_scan();
    xfer_t x, e;
    int c, c_prev, want_gap;
    bit ok;
    exp_q.push_back('{1'b1, 3'h0, 32'h0000_00FF});
    repeat (3) exp_q.push_back('{1'b0, 3'h4, 32'h0});
    idr = 8'h00; in_mask = 8'hFF; period = 16'd4; irq_en = 8'h00;
    scan_en = 1'b1;
    c_prev = 0;
    for (int k = 0; k < 4; k++) begin
      next_xfer(x, c, ok);
      n_vec++;
      if (!ok) begin
        n_err++; $display("FAIL first_scan_timeout: transfer %0d completed=%b required=1", k, ok);
        break;
      end
      e = exp_q.pop_front();
      n_vec++;
      if (x.wr !== e.wr || x.addr !== e.addr || (e.wr && x.wdata !== e.wdata)) begin
        n_err++;
        $display("FAIL first_scan_xfer%0d: got wr=%b addr=%h wdata=%h required wr=%b addr=%h wdata=%h",
                 k, x.wr, x.addr, x.wdata, e.wr, e.addr, e.wdata);
      end
      if (k > 0) begin
        want_gap = (k == 1) ? 3 : 8;
        n_vec++;
        if (c - c_prev != want_gap) begin
          n_err++; $display("FAIL first_scan_gap%0d: got %0d cycles required %0d", k, c - c_prev, want_gap);
        end
      end
      c_prev = c;
    end
    exp_q.delete();
    settle();
    n_vec++;
    if (snapshot !== 8'h00) begin
      n_err++; $display("FAIL first_scan_snapshot: got %h required 00", snapshot);
    end
  endtask

  task automatic test_rise_irq();
    irq_en = 8'h01;
    idr = 8'h05;
    repeat (ACC_SCANS) wait_read();
    settle();
    n_vec++;
    if (snapshot !== 8'h05) begin
      n_err++; $display("FAIL rise_snapshot: got %h required 05", snapshot);
    end
    n_vec++;
    if (rise_flag !== 8'h05) begin
      n_err++; $display("FAIL rise_flag: got %h required 05", rise_flag);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL irq_latency: got %b required 0", irq);
    end
    @(negedge PCLK);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL irq_set: got %b required 1", irq);
    end
    @(negedge PCLK); flag_clr = 8'hFF;
    @(negedge PCLK); flag_clr = 8'h00;
    n_vec++;
    if ({rise_flag, fall_flag} !== 16'h0) begin
      n_err++; $display("FAIL clear_all: got %h required 0000", {rise_flag, fall_flag});
    end
    @(negedge PCLK);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL irq_drop: got %b required 0", irq);
    end
  endtask

  task automatic test_set_wins();
    idr = 8'h04;
    repeat (ACC_SCANS) wait_read();
    settle();
    n_vec++;
    if ({rise_flag, fall_flag} !== 16'h0001) begin
      n_err++; $display("FAIL fall_bit0: got %h required 0001", {rise_flag, fall_flag});
    end
    idr = 8'h05;
    repeat (ACC_SCANS - 1) wait_read();
    wait_read();
    @(posedge PCLK); #1 flag_clr = 8'h01;
    @(posedge PCLK); #1 flag_clr = 8'h00;
    @(negedge PCLK);
    n_vec++;
    if (rise_flag !== 8'h01) begin
      n_err++; $display("FAIL set_wins_rise: got %h required 01", rise_flag);
    end
    n_vec++;
    if (fall_flag !== 8'h00) begin
      n_err++; $display("FAIL set_cycle_clear_fall: got %h required 00", fall_flag);
    end
    @(negedge PCLK); flag_clr = 8'h01;
    @(negedge PCLK); flag_clr = 8'h00;
    n_vec++;
    if (rise_flag !== 8'h00) begin
      n_err++; $display("FAIL later_clear: got %h required 00", rise_flag);
    end
    @(negedge PCLK);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL later_clear_irq: got %b required 0", irq);
    end
  endtask

  task automatic test_mask_change();
    xfer_t x, e;
    int c;
    bit ok;
    idr = 8'hF0;
    repeat (ACC_SCANS) wait_read();
    settle();
    n_vec++;
    if (snapshot !== 8'hF0) begin
      n_err++; $display("FAIL mask_pre_snapshot: got %h required F0", snapshot);
    end
    @(negedge PCLK); flag_clr = 8'hFF;
    @(negedge PCLK); flag_clr = 8'h00;
    in_mask = 8'h0F;
    exp_q.push_back('{1'b1, 3'h0, 32'h0000_000F});
    repeat (ACC_SCANS) exp_q.push_back('{1'b0, 3'h4, 32'h0});
    while (exp_q.size() > 0) begin
      next_xfer(x, c, ok);
      n_vec++;
      if (!ok) begin
        n_err++; $display("FAIL mask_timeout: transfer completed=%b required=1", ok);
        break;
      end
      e = exp_q.pop_front();
      n_vec++;
      if (x.wr !== e.wr || x.addr !== e.addr || (e.wr && x.wdata !== e.wdata)) begin
        n_err++;
        $display("FAIL mask_xfer: got wr=%b addr=%h wdata=%h required wr=%b addr=%h wdata=%h",
                 x.wr, x.addr, x.wdata, e.wr, e.addr, e.wdata);
      end
    end
    exp_q.delete();
    settle();
    n_vec++;
    if (snapshot !== 8'h00) begin
      n_err++; $display("FAIL mask_snapshot: got %h required 00", snapshot);
    end
    n_vec++;
    if ({rise_flag, fall_flag} !== 16'h00F0) begin
      n_err++; $display("FAIL mask_fall: got %h required 00F0", {rise_flag, fall_flag});
    end
  endtask

  task automatic test_debounce();
`ifdef GPI_SCAN_DEBOUNCE_EN
    idr = 8'h01; wait_read(); settle();
    idr = 8'h00; wait_read(); settle();
    n_vec++;
    if ({snapshot, rise_flag} !== 16'h0000) begin
      n_err++; $display("FAIL glitch_filtered: got %h required 0000", {snapshot, rise_flag});
    end
    idr = 8'h01; wait_read(); wait_read(); settle();
    n_vec++;
    if (snapshot !== 8'h01) begin
      n_err++; $display("FAIL held_accepted: got %h required 01", snapshot);
    end
`else
    idr = 8'h01; wait_read(); settle();
    n_vec++;
    if ({snapshot, rise_flag} !== 16'h0101) begin
      n_err++; $display("FAIL no_filter_rise: got %h required 0101", {snapshot, rise_flag});
    end
    idr = 8'h00; wait_read(); settle();
    n_vec++;
    if ({snapshot, fall_flag} !== 16'h00F1) begin
      n_err++; $display("FAIL no_filter_fall: got %h required 00F1", {snapshot, fall_flag});
    end
`endif
  endtask

  task automatic test_stall_drop();
    int acc;
    bit found;
    stall = 3;
    idr = 8'h0A;
    repeat (ACC_SCANS - 1) wait_read();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge PCLK);
      if (M_PSEL && M_PENABLE && !M_PWRITE) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++; $display("FAIL stall_no_access: found=%b required=1", found);
    end
    scan_en = 1'b0;
    acc = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (!M_PSEL) break;
      acc++;
    end
    n_vec++;
    if (acc != 5) begin
      n_err++; $display("FAIL stall_psel_held: got %0d access cycles required 5", acc);
    end
    @(negedge PCLK);
    n_vec++;
    if ({busy, M_PSEL} !== 2'b00) begin
      n_err++; $display("FAIL drop_idle: busy/psel got %b required 00", {busy, M_PSEL});
    end
    n_vec++;
    if (snapshot !== 8'h0A) begin
      n_err++; $display("FAIL drop_update: got %h required 0A", snapshot);
    end
    repeat (6) @(negedge PCLK);
    n_vec++;
    if ({busy, M_PSEL} !== 2'b00) begin
      n_err++; $display("FAIL stays_idle: busy/psel got %b required 00", {busy, M_PSEL});
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    scan_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge PCLK);
      if (M_PSEL && M_PENABLE) found = 1'b1;
    end
    n_vec++;
    if (!found) begin
      n_err++; $display("FAIL reset_mid_no_access: found=%b required=1", found);
    end
    PRESET = 1'b1;
    #1;
    n_vec++;
    if ({M_PSEL, M_PENABLE, busy} !== 3'b000) begin
      n_err++; $display("FAIL reset_mid_apb: psel/penable/busy got %b required 000", {M_PSEL, M_PENABLE, busy});
    end
    n_vec++;
    if ({snapshot, rise_flag, fall_flag, irq} !== 25'h0) begin
      n_err++; $display("FAIL reset_mid_data: got %h required 0", {snapshot, rise_flag, fall_flag, irq});
    end
    @(negedge PCLK);
    scan_en = 1'b0;
    stall = 0;
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_first_scan();
    test_rise_irq();
    test_set_wins();
    test_mask_change();
    test_debounce();
    test_stall_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
